cmp_seq_ctrl: RTL

- Sequencer that loads two WIDTH-bit operands nibble-wise from a shared half-width input using four pushbutton strobes.
- Compares the operands serially, MSB first, through a single 1-bit compare cell stage, so one compare slice is time-shared over the whole operand.
- Reports less, greater and equal flags, plus busy, done and valid status.
- Sits between the board switches and buttons and the magnitude-compare result LEDs.

---
 rtl/cmp_seq_ctrl_if.sv | 29 ++
 rtl/cmp_seq_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/cmp_seq_ctrl_if.sv
// Board-side bundle for the serial magnitude comparator: button and shared operand inputs,
// start request, and the status, flag and operand-register outputs.
interface cmp_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   localparam int HALF = WIDTH / 2;

   logic [3:0]       pb;
   logic [HALF-1:0]  c;
   logic             start;
   logic             busy;
   logic             done;
   logic             valid;
   logic             l;
   logic             g;
   logic             e;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   modport master (
      output pb, c, start,
      input  busy, done, valid, l, g, e, a_q, b_q
   );

   modport slave (
      input  pb, c, start,
      output busy, done, valid, l, g, e, a_q, b_q
   );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Loads two operands half-word at a time from button strobes, then compares them MSB first
// through one time-shared 1-bit compare cell, publishing l/g/e together with valid.
module cmp_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            reset,
   cmp_seq_ctrl_if.slave  bus
);
   localparam int HALF = WIDTH / 2;
   localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       pb_d;
   logic             start_d;
   logic [3:0]       rise;
   logic             srise;
   logic             load_ok;
   logic [WIDTH-1:0] a_r, b_r;
   logic [WIDTH-1:0] sa, sb;
   logic [IW-1:0]    idx;
   logic [2:0]       res;
   logic             valid_r, l_r, g_r, e_r;
   logic             bit_a, bit_b;
   logic             snap, step, fin;

   assign rise    = bus.pb & ~pb_d;
   assign srise   = bus.start & ~start_d;
   assign load_ok = (state_q != CMP) && (rise != 4'b0000);

   always_comb begin
      state_d = state_q;
      snap    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      bit_a   = sa[idx];
      bit_b   = sb[idx];
      case (state_q)
         IDLE: begin
            if (srise) begin
               snap    = 1'b1;
               state_d = CMP;
            end
         end
         CMP: begin
            if ((bit_a != bit_b) || (idx == '0)) begin
               fin     = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pb_d    <= 4'b1111;
         start_d <= 1'b1;
         a_r     <= '0;
         b_r     <= '0;
         idx     <= '0;
         res     <= '0;
         valid_r <= 1'b0;
         l_r     <= 1'b0;
         g_r     <= 1'b0;
         e_r     <= 1'b0;
      end else begin
         state_q <= state_d;
         pb_d    <= bus.pb;
         start_d <= bus.start;
         if (state_q != CMP) begin
            if (rise[0]) a_r[HALF-1:0]     <= bus.c;
            if (rise[1]) a_r[WIDTH-1:HALF] <= bus.c;
            if (rise[2]) b_r[HALF-1:0]     <= bus.c;
            if (rise[3]) b_r[WIDTH-1:HALF] <= bus.c;
         end
         if (snap) idx <= IW'(WIDTH - 1);
         else if (step) idx <= idx - 1'b1;
         if (fin) res <= {~bit_a & bit_b, bit_a & ~bit_b, bit_a == bit_b};
         // A load landing in DONE wins: the pending result no longer describes the registers.
         if (load_ok || snap) begin
            valid_r <= 1'b0;
            l_r     <= 1'b0;
            g_r     <= 1'b0;
            e_r     <= 1'b0;
         end else if (state_q == DONE) begin
            valid_r           <= 1'b1;
            {l_r, g_r, e_r}   <= res;
         end
      end
   end

   // Snapshot keeps the compare immune to loads and c activity while in CMP.
   always_ff @(posedge clk) begin
      if (snap) begin
         sa <= a_r;
         sb <= b_r;
      end
   end

   assign bus.busy  = (state_q == CMP);
   assign bus.done  = (state_q == DONE);
   assign bus.valid = valid_r;
   assign bus.l     = l_r;
   assign bus.g     = g_r;
   assign bus.e     = e_r;
   assign bus.a_q   = a_r;
   assign bus.b_q   = b_r;
endmodule
